note_cmd_out_fifo: RTL and testbench

//  Avalon-MM slave output port: the Nios CPU writes note commands, and this block

---
 rtl/note_cmd_out_fifo_if.sv | 27 ++
 rtl/note_cmd_out_fifo.sv | 122 ++++++++++++
 tb/tb_note_cmd_out_fifo.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/note_cmd_out_fifo_if.sv
// rtl/note_cmd_out_fifo_if.sv - s1 register bus and voice-side command stream bundle
interface note_cmd_out_fifo_if #(
    parameter int DATA_W = 8
);
    // s1 register port
    logic [1:0]        address;
    logic              chipselect;
    logic              write;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    // voice-engine command stream
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    // CPU and voice engine side
    modport master (
        output address, chipselect, write, writedata, out_ready,
        input  readdata, out_data, out_valid
    );

    // FIFO block side
    modport slave (
        input  address, chipselect, write, writedata, out_ready,
        output readdata, out_data, out_valid
    );
endinterface

// File: rtl/note_cmd_out_fifo.sv
// rtl/note_cmd_out_fifo.sv - CPU-written note command FIFO feeding the voice engine
module note_cmd_out_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    note_cmd_out_fifo_if.slave     s
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          ovf_q,    ovf_d;
    logic [31:0]   readdata_q, readdata_d;

    logic          empty;
    logic          full;
    logic          bus_wr;
    logic          push_req;
    logic          pop_req;
    logic          flush;
    logic          clr_ovf;
    logic          push_ok;
    logic          pop_ok;
    logic [7:0]    count8;
    logic          unused_ok;

    // writedata bits above the command width have no destination
    assign unused_ok = &{1'b0, s.writedata};

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign count8 = 8'(count_q);

    assign bus_wr   = s.chipselect & s.write;
    assign push_req = bus_wr & (s.address == ADDR_DATA);
    assign flush    = bus_wr & (s.address == ADDR_CTRL)   & s.writedata[0];
    assign clr_ovf  = bus_wr & (s.address == ADDR_STATUS) & s.writedata[0];
    assign pop_req  = ~empty & s.out_ready;

    // flush wins over both sides; a full FIFO still accepts when the head leaves this cycle
    assign pop_ok  = pop_req & ~flush;
    assign push_ok = push_req & ~flush & (~full | pop_req);

    assign s.out_valid = ~empty;
    assign s.out_data  = mem_q[rd_ptr_q];
    assign s.readdata  = readdata_q;

    // next pointer, count and overflow state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - CW'(1);
            end
        end
        // set has priority over clear so an overflow is never lost
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (push_req && !flush && full && !pop_req) begin
            ovf_d = 1'b1;
        end
    end

    // register read mux, evaluated every cycle regardless of chipselect
    always_comb begin
        readdata_d = 32'd0;
        case (s.address)
            ADDR_STATUS: readdata_d = {21'd0, ovf_q, full, empty, count8};
            default:     readdata_d = 32'd0;
        endcase
    end

    // control state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            readdata_q <= 32'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            readdata_q <= readdata_d;
        end
    end

    // command storage; contents are not reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= s.writedata[DATA_W-1:0];
        end
    end
endmodule

// File: tb/tb_note_cmd_out_fifo.sv
// tb/tb_note_cmd_out_fifo.sv - randomized self-checking bench for note_cmd_out_fifo
module tb_note_cmd_out_fifo;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    logic [DATA_W-1:0] mq[$];
    logic              movf;

    note_cmd_out_fifo_if #(.DATA_W(DATA_W)) bus ();

    note_cmd_out_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_status();
        logic [31:0] v;
        v = 32'(mq.size());
        if (mq.size() == 0)     v = v | 32'h100;
        if (mq.size() == DEPTH) v = v | 32'h200;
        if (movf)               v = v | 32'h400;
        return v;
    endfunction

    // one bus cycle: check head before the edge, apply the model, check readdata after
    task automatic step(input logic cs, input logic wr, input logic [1:0] a,
                        input logic [31:0] wd, input logic rdy, input string tag);
        logic [31:0] exp_rd;
        logic        pop;
        logic        flush;
        logic        push;
        bus.chipselect = cs;
        bus.write      = wr;
        bus.address    = a;
        bus.writedata  = wd;
        bus.out_ready  = rdy;
        #1;
        n_checks++;
        if (bus.out_valid !== (mq.size() != 0)) begin
            n_fail++;
            $display("FAIL %s out_valid: got %b want %b", tag, bus.out_valid, mq.size() != 0);
        end
        if (mq.size() != 0) begin
            n_checks++;
            if (bus.out_data !== mq[0]) begin
                n_fail++;
                $display("FAIL %s out_data: got %h want %h", tag, bus.out_data, mq[0]);
            end
        end
        exp_rd = (a == 2'd1) ? model_status() : 32'd0;
        flush  = cs && wr && a == 2'd2 && wd[0];
        push   = cs && wr && a == 2'd0;
        pop    = rdy && mq.size() != 0;
        @(posedge clk);
        #1;
        if (flush) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(wd[DATA_W-1:0]);
                else                   movf = 1'b1;
            end
        end
        if (cs && wr && a == 2'd1 && wd[0]) movf = 1'b0;
        n_checks++;
        if (bus.readdata !== exp_rd) begin
            n_fail++;
            $display("FAIL %s readdata: got %h want %h", tag, bus.readdata, exp_rd);
        end
    endtask

    task automatic push_w(input logic [31:0] d, input logic rdy, input string tag);
        step(1'b1, 1'b1, 2'd0, d, rdy, tag);
    endtask

    task automatic read_status(input string tag);
        step(1'b0, 1'b0, 2'd1, 32'd0, 1'b0, tag);
        step(1'b0, 1'b0, 2'd1, 32'd0, 1'b0, tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, tag);
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.address    = 2'd0;
        bus.writedata  = 32'd0;
        bus.out_ready  = 1'b0;
        mq.delete();
        movf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.readdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset: out_valid %b readdata %h want 0 0", bus.out_valid, bus.readdata);
        end
        step(1'b0, 1'b0, 2'd1, 32'd0, 1'b0, "reset_status");
        n_checks++;
        if (bus.readdata !== 32'h100) begin
            n_fail++;
            $display("FAIL reset_status_const: got %h want 00000100", bus.readdata);
        end
    endtask

    task automatic test_single();
        push_w(32'h3C, 1'b0, "single_push");
        read_status("single_status");
        n_checks++;
        if (bus.readdata !== 32'h001 || bus.out_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL single: readdata %h out_data %h want 00000001 3c", bus.readdata, bus.out_data);
        end
        drain("single_drain");
    endtask

    task automatic test_full_ovf();
        for (int i = 1; i <= DEPTH; i++) push_w(32'(i), 1'b0, "fill");
        read_status("full_status");
        push_w(32'h11, 1'b0, "ovf_push");
        read_status("ovf_status");
        n_checks++;
        if (bus.readdata !== 32'h610) begin
            n_fail++;
            $display("FAIL ovf_status_const: got %h want 00000610", bus.readdata);
        end
        drain("full_drain");
    endtask

    task automatic test_full_pop_wrap();
        for (int i = 0; i < DEPTH; i++) push_w(32'($urandom_range(255)), 1'b0, "wrap_fill");
        push_w(32'h55, 1'b1, "full_pop_push");
        read_status("full_pop_status");
        for (int i = 0; i < 40; i++)
            step(1'b1, $urandom_range(1), 2'd0, 32'($urandom_range(255)), $urandom_range(1), "wrap_mix");
        drain("wrap_drain");
    endtask

    task automatic test_flush_clear();
        for (int i = 0; i < 3; i++) push_w(32'(8'hA0 + i), 1'b0, "flush_fill");
        step(1'b1, 1'b1, 2'd2, 32'h1, 1'b1, "flush");
        read_status("flush_status");
        step(1'b1, 1'b1, 2'd1, 32'h1, 1'b0, "clr_ovf");
        read_status("clr_status");
        push_w(32'h77, 1'b0, "flush_push");
        step(1'b1, 1'b1, 2'd2, 32'h1, 1'b1, "flush_vs_pop");
        read_status("flush2_status");
        for (int i = 0; i < DEPTH + 1; i++) push_w(32'(i), 1'b0, "ovf_again");
        step(1'b1, 1'b1, 2'd2, 32'h1, 1'b0, "flush_keep_ovf");
        read_status("ovf_kept_status");
        step(1'b1, 1'b1, 2'd1, 32'h1, 1'b0, "clr_ovf2");
        read_status("clr2_status");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) push_w(32'(8'hC0 + i), 1'b0, "mid_fill");
        step(1'b0, 1'b0, 2'd1, 32'd0, 1'b0, "mid_addr");
        reset_n        = 1'b0;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.address    = 2'd1;
        #1;
        mq.delete();
        movf = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.readdata !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset: out_valid %b readdata %h want 0 0", bus.out_valid, bus.readdata);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        push_w(32'hE7, 1'b0, "post_reset_push");
        step(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, "post_reset_pop");
        read_status("post_reset_status");
    endtask

    task automatic test_random();
        logic [1:0] a;
        logic [31:0] wd;
        for (int i = 0; i < 400; i++) begin
            a  = 2'($urandom_range(3));
            wd = $urandom();
            if (a == 2'd2 && $urandom_range(7) != 0) wd[0] = 1'b0;
            if (a == 2'd0 && $urandom_range(1) == 0) a = 2'd0;
            step($urandom_range(1), $urandom_range(1), a, wd, ($urandom_range(3) == 0), "random");
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_full_ovf();
        test_full_pop_wrap();
        test_flush_clear();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
